// File: rtl/counter_modn_if.sv
// rtl/counter_modn_if.sv - control and status bundle for the modulo-N counter
interface counter_modn_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             load;
  logic             mode;
  logic             hold;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             tc;
  logic             load_err;
  logic             done;

  modport master (
    output en, load, mode, hold, data_in,
    input  data_out, tc, load_err, done
  );

  modport slave (
    input  en, load, mode, hold, data_in,
    output data_out, tc, load_err, done
  );
endinterface

// File: rtl/counter_modn.sv
// rtl/counter_modn.sv - modulo-N up/down counter with load clamping, wrap/hold and tc pulse
module counter_modn #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 12
) (
  input  logic           clk,
  input  logic           rst,
  counter_modn_if.slave  bus
);

  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
    $error("counter_modn: MODULUS %0d illegal for WIDTH %0d", MODULUS, WIDTH);
  end

  // One extra bit so MODULUS == 2**WIDTH is representable in the compares.
  localparam logic [WIDTH:0]   MOD_EXT  = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0]   TERM_EXT = MOD_EXT - (WIDTH+1)'(1);
  localparam logic [WIDTH-1:0] TERM     = TERM_EXT[WIDTH-1:0];

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             err_q, err_d;
  logic             done_q, done_d;
  logic             in_range;
  logic             at_top;
  logic             at_zero;

  assign in_range = ({1'b0, bus.data_in} < MOD_EXT);
  assign at_top   = ({1'b0, count_q} == TERM_EXT);
  assign at_zero  = (count_q == '0);

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    err_d   = 1'b0;
    done_d  = done_q;
    if (bus.load) begin
      count_d = in_range ? bus.data_in : TERM;
      err_d   = ~in_range;
      done_d  = 1'b0;
    end else if (bus.en) begin
      if (bus.mode) begin
        if (!at_top) begin
          count_d = count_q + WIDTH'(1);
        end else if (bus.hold) begin
          done_d = 1'b1;
        end else begin
          count_d = '0;
          tc_d    = 1'b1;
        end
      end else begin
        if (!at_zero) begin
          count_d = count_q - WIDTH'(1);
        end else if (bus.hold) begin
          done_d = 1'b1;
        end else begin
          count_d = TERM;
          tc_d    = 1'b1;
        end
      end
      // Any movement means the counter is no longer parked.
      if (count_d != count_q) begin
        done_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign bus.data_out = count_q;
  assign bus.tc       = tc_q;
  assign bus.load_err = err_q;
  assign bus.done     = done_q;

endmodule

// File: doc/counter_modn.md
Name: counter_modn

Overview:
- Parametrised modulo-N up/down counter with synchronous load. It is the generalised successor of the team's fixed mod-12 counter.
- Adds count enable, selectable wrap/hold-at-terminal behaviour, a terminal-count pulse, load range checking and a sticky done flag.
- Used as a timebase/sequence counter. Designed to be cascaded through tc into a following counter's en.

Parameters:
- WIDTH, 4, counter and data width in bits.
- MODULUS, 12, count range 0..MODULUS-1. Legal range 2 <= MODULUS <= 2**WIDTH. An illegal value is an elaboration-time error ($error).

Ports:
- clk  input  1  clock; all logic on posedge clk.
- rst  input  1  synchronous reset, active high.
- en  input  1  count enable.
- load  input  1  synchronous load strobe.
- mode  input  1  count direction: 1 = up, 0 = down.
- hold  input  1  terminal behaviour: 0 = wrap, 1 = stop at terminal value.
- data_in  input  WIDTH  load value.
- data_out  output  WIDTH  registered count.
- tc  output  1  registered 1-cycle pulse on a wrap.
- load_err  output  1  registered 1-cycle pulse when a load value is out of range.
- done  output  1  registered sticky flag: counter is parked at terminal in hold mode.

Behaviour:
- Everything is synchronous to posedge clk. All outputs are registered, so changes are visible the cycle after the causing edge.
- Priority order: rst > load > en. When none is active, data_out holds.

rst = 1:
- data_out = 0, tc = 0, load_err = 0, done = 0.
- Overrides load and en in the same cycle, including mid-count and mid-load.

load = 1 (en ignored):
- If data_in < MODULUS: data_out <= data_in, load_err <= 0.
- Else: data_out <= MODULUS-1 (clamped) and load_err <= 1 for one cycle.
- done <= 0 and tc <= 0 in both cases.

en = 1, mode = 1 (up):
- data_out < MODULUS-1: data_out <= data_out+1.
- data_out == MODULUS-1 and hold = 0: data_out <= 0, tc <= 1.
- data_out == MODULUS-1 and hold = 1: data_out holds, done <= 1, no tc.

en = 1, mode = 0 (down):
- data_out > 0: data_out <= data_out-1.
- data_out == 0 and hold = 0: data_out <= MODULUS-1, tc <= 1.
- data_out == 0 and hold = 1: data_out holds, done <= 1, no tc.

Pulse and flag rules:
- tc and load_err are pulses. They are 0 in every cycle not explicitly setting them, including en = 0 cycles.
- done is cleared on any cycle where data_out changes value, and by load or rst. Otherwise it stays set.
- Example: with done set at terminal, flipping mode moves the counter away and clears done on the same edge.

Boundary and timing rules:
- mode and hold are sampled every edge. Changing either mid-count takes effect at the next enabled edge, with no pipeline delay.
- When MODULUS == 2**WIDTH, the wrap comparison must still use MODULUS-1 explicitly.
- Arithmetic is done in WIDTH+1 bits internally to avoid truncation of MODULUS. data_out never exceeds MODULUS-1.
- Continuous en wraps: tc period = MODULUS cycles in either direction. Cascading tc into a second instance's en forms a multi-digit counter.
- en = 0 freezes the count. A pending terminal condition does not generate tc until en returns.

Test Plan:
- Defaults (WIDTH=4, MODULUS=12):
  - rst, then en=1 mode=1 hold=0 for 13 cycles -> data_out 0,1..11,0. tc high only on the cycle data_out shows 0 after 11.
  - load=1 data_in=5 -> data_out=5, load_err=0.
  - load=1 data_in=14 -> data_out=11, load_err pulses 1 cycle.
  - load with rst=1 together -> data_out=0.
  - load 2, mode=0 hold=1 en=1 for 4 cycles -> 2,1,0,0. done=1 from the first cycle parked at 0, tc never asserted. Then mode=1 -> data_out=1, done=0.
  - Count up to 7, en=0 for 3 cycles -> data_out holds 7, tc=0. Assert rst mid-count -> data_out=0 next cycle, all flags 0.
- WIDTH=8, MODULUS=200:
  - Load 199, en=1 mode=1 -> data_out=0, tc=1.
  - Load 250 -> data_out=199, load_err=1.
  - mode=0 from 0 -> data_out=199, tc=1.
- WIDTH=4, MODULUS=16: 17 up-counts from 0 -> wraps 15 to 0 with tc. Confirms the full-range modulus case.
